xbar_rr_arbiter: RTL

- Shares one crossbar output port among N_REQ per-input request queues, using packet-granular round-robin.
- Each requester presents a first-word-fall-through word stream: valid, data and last flag. The arbiter pops the granted queue and drives a registered valid/ready output stage toward the output port.
- A grant is held from the first beat to the `last` beat, so packets are never interleaved.

---
 rtl/xbar_arb_pkg.sv | 14 +
 rtl/xbar_rr_pick.sv | 38 +++
 rtl/xbar_rr_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/xbar_arb_pkg.sv
// Shared types and helpers for the crossbar output-port round-robin arbiter.
package xbar_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Wrapped increment of a requester index: idx+1, or 0 after the last index.
    function automatic int rr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/xbar_rr_pick.sv
// Rotating priority encoder: finds the first set request at or above i_rrPtr,
// wrapping modulo N_REQ. Purely combinational.
module xbar_rr_pick
    import xbar_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDW-1:0]   i_rrPtr,
    output logic             o_found,
    output logic [IDW-1:0]   o_idx
);

    logic [N_REQ-1:0] w_rot;
    int               w_sum;

    // Rotate the request vector so bit 0 corresponds to the requester at i_rrPtr.
    assign w_rot = N_REQ'({i_req, i_req} >> i_rrPtr);

    // Lowest set rotated bit wins; map it back to an absolute index with an explicit wrap.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_sum   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_found = 1'b1;
                w_sum   = int'(i_rrPtr) + k;
                if (w_sum >= N_REQ) begin
                    w_sum = w_sum - N_REQ;
                end
                o_idx = IDW'(w_sum);
            end
        end
    end

endmodule

// File: rtl/xbar_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one crossbar output port among
// N_REQ first-word-fall-through request queues, with a registered valid/ready
// output stage. A grant is held from the first beat to the last beat.
// Optional macro XBAR_ARB_PRIO_EN: requester 0 becomes strict high priority and
// the round-robin rotates over requesters 1..N_REQ-1 only.
module xbar_rr_arbiter
    import xbar_arb_pkg::*;
#(
    parameter  int N_REQ  = 4,
    parameter  int DWIDTH = 32,
    localparam int IDW    = $clog2(N_REQ)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DWIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_pop,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DWIDTH-1:0]       out_data,
    output logic                    out_last,
    output logic [IDW-1:0]          out_id,
    output logic                    busy
);

`ifdef XBAR_ARB_PRIO_EN
    // Requester 0 is never part of the rotation, so the pointer starts at 1.
    localparam logic [IDW-1:0] RR_RESET = IDW'(1);
`else
    localparam logic [IDW-1:0] RR_RESET = '0;
`endif

    arb_state_t        r_state;
    arb_state_t        w_stateNext;
    logic [IDW-1:0]    r_grant;
    logic [IDW-1:0]    w_grantNext;
    logic [IDW-1:0]    r_rrPtr;
    logic [IDW-1:0]    w_rrPtrNext;

    logic              r_outValid;
    logic [DWIDTH-1:0] r_outData;
    logic              r_outLast;
    logic [IDW-1:0]    r_outId;

    logic [N_REQ-1:0]  w_pickReq;
    logic              w_pickFound;
    logic [IDW-1:0]    w_pickIdx;
    logic              w_selFound;
    logic [IDW-1:0]    w_selIdx;

    logic              w_grantValid;
    logic              w_grantLast;
    logic [DWIDTH-1:0] w_grantData;
    logic              w_load;

`ifdef XBAR_ARB_PRIO_EN
    assign w_pickReq  = {req_valid[N_REQ-1:1], 1'b0};
    assign w_selFound = req_valid[0] | w_pickFound;
    assign w_selIdx   = req_valid[0] ? '0 : w_pickIdx;
`else
    assign w_pickReq  = req_valid;
    assign w_selFound = w_pickFound;
    assign w_selIdx   = w_pickIdx;
`endif

    xbar_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .i_req   (w_pickReq),
        .i_rrPtr (r_rrPtr),
        .o_found (w_pickFound),
        .o_idx   (w_pickIdx)
    );

    // Select the head word, valid and last flag of the currently granted requester.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantLast  = 1'b0;
        w_grantData  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant == IDW'(i)) begin
                w_grantValid = req_valid[i];
                w_grantLast  = req_last[i];
                w_grantData  = req_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    assign w_load = (r_state == LOCKED) & w_grantValid & (~r_outValid | out_ready);

    // Pop strobe goes only to the granted requester, and only when its word is loaded.
    always_comb begin
        req_pop = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant == IDW'(i)) begin
                req_pop[i] = w_load;
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, release the lock after the last beat is loaded.
    always_comb begin
        w_stateNext = r_state;
        w_grantNext = r_grant;
        w_rrPtrNext = r_rrPtr;
        case (r_state)
            IDLE: begin
                if (w_selFound) begin
                    w_stateNext = LOCKED;
                    w_grantNext = w_selIdx;
                end
            end
            LOCKED: begin
                if (w_load && w_grantLast) begin
                    w_stateNext = IDLE;
`ifdef XBAR_ARB_PRIO_EN
                    // Serving the priority requester leaves the rotation untouched.
                    if (r_grant != '0) begin
                        w_rrPtrNext = IDW'(rr_next(int'(r_grant), N_REQ));
                        if (w_rrPtrNext == '0) begin
                            w_rrPtrNext = IDW'(1);
                        end
                    end
`else
                    w_rrPtrNext = IDW'(rr_next(int'(r_grant), N_REQ));
`endif
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_rrPtr <= RR_RESET;
        end else begin
            r_state <= w_stateNext;
            r_grant <= w_grantNext;
            r_rrPtr <= w_rrPtrNext;
        end
    end

    // Output register: load a new word, drain on handshake, otherwise hold stable.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outLast  <= 1'b0;
            r_outId    <= '0;
        end else if (w_load) begin
            r_outValid <= 1'b1;
            r_outData  <= w_grantData;
            r_outLast  <= w_grantLast;
            r_outId    <= r_grant;
        end else if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_last  = r_outLast;
    assign out_id    = r_outId;
    assign busy      = (r_state == LOCKED);

endmodule
